// File: rtl/alarma_multicanal.sv
// ---------------------------------------------------------------------------
// alarma_multicanal
//
// Multi-channel alarm clock controller. Each channel holds an HH:MM alarm
// time in BCD and has its own enable bit. When a new minute starts and
// one or more enabled channels match the current time, the alarm rings.
// The lowest matching channel index owns the alarm. While ringing, the user
// can stop the alarm or snooze it. The alarm also switches itself off after
// RING_MIN minutes with no user action.
//
// Parameters
//   N_ALARMAS  : number of alarm channels (1..8)
//   SNOOZE_MIN : snooze length in minute ticks (1..15)
//   RING_MIN   : ring auto-off timeout in minute ticks (1..15)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   uhre       in   current time, hour units   (BCD)
//   dhre       in   current time, hour tens    (BCD)
//   umre       in   current time, minute units (BCD)
//   dmre       in   current time, minute tens  (BCD)
//   min_tick   in   one-cycle pulse on the first cycle of a new minute
//   al_time    in   packed alarm times, channel k at [16k+15:16k] = {dh,uh,dm,um}
//   al_en      in   per-channel alarm enable
//   snooze     in   one-cycle snooze request
//   stop       in   one-cycle stop request
//   enc        out  alarm sounding (registered)
//   pospuesto  out  snooze pending (registered)
//   canal      out  index of the channel owning the current alarm (registered)
// ---------------------------------------------------------------------------
module alarma_multicanal #(
    parameter int N_ALARMAS  = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [3:0]                uhre,
    input  logic [3:0]                dhre,
    input  logic [3:0]                umre,
    input  logic [3:0]                dmre,
    input  logic                      min_tick,
    input  logic [16*N_ALARMAS-1:0]   al_time,
    input  logic [N_ALARMAS-1:0]      al_en,
    input  logic                      snooze,
    input  logic                      stop,
    output logic                      enc,
    output logic                      pospuesto,
    output logic [2:0]                canal
);

    localparam logic [3:0] SNZ_LIM  = 4'(SNOOZE_MIN);
    localparam logic [3:0] RING_LIM = 4'(RING_MIN);

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        SONANDO   = 2'd1,
        POSPUESTO = 2'd2
    } estado_t;

    estado_t     estado;
    logic [3:0]  cnt_ring;
    logic [3:0]  cnt_snz;

    // Current time in the same digit order as one al_time channel.
    logic [15:0] hora_act;
    assign hora_act = {dhre, uhre, dmre, umre};

    // Per-channel match: raw digit equality, gated by the channel enable.
    logic [N_ALARMAS-1:0] coincide;
    always_comb begin
        coincide = '0;
        for (int k = 0; k < N_ALARMAS; k++) begin
            coincide[k] = al_en[k] && (al_time[16*k +: 16] == hora_act);
        end
    end

    // Lowest matching index wins: scan from the top so the last hit is lowest.
    logic [2:0] canal_min;
    logic       hay_coinc;
    always_comb begin
        canal_min = 3'd0;
        for (int k = N_ALARMAS - 1; k >= 0; k--) begin
            if (coincide[k]) begin
                canal_min = 3'(k);
            end
        end
        hay_coinc = |coincide;
    end

    // Enable vector widened to 8 bits so any 3-bit canal value indexes safely.
    logic [7:0] en_ext;
    logic       canal_activo;
    always_comb begin
        en_ext                 = 8'd0;
        en_ext[N_ALARMAS-1:0]  = al_en;
        canal_activo           = en_ext[canal];
    end

    // Next value of the ring counter on a minute tick; holds at 15 rather
    // than wrapping.
    logic [3:0] ring_sig;
    assign ring_sig = (cnt_ring == 4'hF) ? cnt_ring : cnt_ring + 4'd1;

    // Snooze expires on the tick that takes the counter to zero; a zero
    // counter is treated the same so it can never underflow.
    logic snz_fin;
    assign snz_fin = (cnt_snz <= 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= REPOSO;
            enc       <= 1'b0;
            pospuesto <= 1'b0;
            canal     <= 3'd0;
            cnt_ring  <= 4'd0;
            cnt_snz   <= 4'd0;
        end else begin
            case (estado)
                REPOSO: begin
                    // canal keeps the last owner until a new trigger.
                    if (min_tick && hay_coinc) begin
                        estado    <= SONANDO;
                        enc       <= 1'b1;
                        pospuesto <= 1'b0;
                        canal     <= canal_min;
                        cnt_ring  <= 4'd0;
                    end
                end

                SONANDO: begin
                    // Disabling the owning channel overrides everything else,
                    // then stop, then snooze, then the timeout.
                    if (!canal_activo || stop) begin
                        estado    <= REPOSO;
                        enc       <= 1'b0;
                        pospuesto <= 1'b0;
                        cnt_ring  <= 4'd0;
                        cnt_snz   <= 4'd0;
                    end else if (snooze) begin
                        estado    <= POSPUESTO;
                        enc       <= 1'b0;
                        pospuesto <= 1'b1;
                        cnt_snz   <= SNZ_LIM;
                    end else if (min_tick) begin
                        if (ring_sig == RING_LIM) begin
                            estado    <= REPOSO;
                            enc       <= 1'b0;
                            pospuesto <= 1'b0;
                            cnt_ring  <= 4'd0;
                            cnt_snz   <= 4'd0;
                        end else begin
                            cnt_ring  <= ring_sig;
                        end
                    end
                end

                POSPUESTO: begin
                    // Snooze requests are ignored here; only stop, disable
                    // and the snooze countdown act.
                    if (!canal_activo || stop) begin
                        estado    <= REPOSO;
                        enc       <= 1'b0;
                        pospuesto <= 1'b0;
                        cnt_ring  <= 4'd0;
                        cnt_snz   <= 4'd0;
                    end else if (min_tick) begin
                        if (snz_fin) begin
                            estado    <= SONANDO;
                            enc       <= 1'b1;
                            pospuesto <= 1'b0;
                            cnt_ring  <= 4'd0;
                            cnt_snz   <= 4'd0;
                        end else begin
                            cnt_snz   <= cnt_snz - 4'd1;
                        end
                    end
                end

                default: begin
                    estado    <= REPOSO;
                    enc       <= 1'b0;
                    pospuesto <= 1'b0;
                    cnt_ring  <= 4'd0;
                    cnt_snz   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarma_multicanal.sv
// ---------------------------------------------------------------------------
// tb_alarma_multicanal
//
// Directed bench for alarma_multicanal with default parameters
// (4 channels, 5-minute snooze, 10-minute ring timeout). Inputs change
// 1 time unit after a rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_alarma_multicanal;

    logic        clk;
    logic        rst_n;
    logic [3:0]  uhre, dhre, umre, dmre;
    logic        min_tick;
    logic [63:0] al_time;
    logic [3:0]  al_en;
    logic        snooze;
    logic        stop;
    logic        enc;
    logic        pospuesto;
    logic [2:0]  canal;

    int n_chk  = 0;
    int n_fail = 0;

    alarma_multicanal #(
        .N_ALARMAS  (4),
        .SNOOZE_MIN (5),
        .RING_MIN   (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uhre      (uhre),
        .dhre      (dhre),
        .umre      (umre),
        .dmre      (dmre),
        .min_tick  (min_tick),
        .al_time   (al_time),
        .al_en     (al_en),
        .snooze    (snooze),
        .stop      (stop),
        .enc       (enc),
        .pospuesto (pospuesto),
        .canal     (canal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] hhmm(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic set_time(input int h, input int m);
        dhre = 4'(h / 10);
        uhre = 4'(h % 10);
        dmre = 4'(m / 10);
        umre = 4'(m % 10);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        min_tick = 1'b1;
        step();
        min_tick = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b1;
        min_tick = 1'b0;
        snooze   = 1'b0;
        stop     = 1'b0;
        al_en    = 4'b0000;
        al_time  = '0;
        set_time(0, 0);

        // Reset
        #2 rst_n = 1'b0;
        #1;
        chk("rst_enc", 8'(enc), 8'd0);
        chk("rst_pos", 8'(pospuesto), 8'd0);
        chk("rst_canal", 8'(canal), 8'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Channel 2 at 07:30
        al_time = {hhmm(6, 0), hhmm(7, 30), hhmm(8, 15), hhmm(6, 0)};
        al_en   = 4'b0100;
        set_time(7, 29);
        tick();
        chk("pre_match_enc", 8'(enc), 8'd0);
        set_time(7, 30);
        tick();
        chk("match_enc", 8'(enc), 8'd1);
        chk("match_canal", 8'(canal), 8'd2);
        chk("match_pos", 8'(pospuesto), 8'd0);
        for (int i = 0; i < 3; i++) step();
        chk("hold_enc", 8'(enc), 8'd1);
        chk("hold_canal", 8'(canal), 8'd2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_enc", 8'(enc), 8'd0);
        for (int i = 0; i < 3; i++) step();
        chk("no_retrigger", 8'(enc), 8'd0);

        // Channels 0 and 3 both at 06:00: lowest wins
        al_en = 4'b1001;
        set_time(6, 0);
        tick();
        chk("dual_enc", 8'(enc), 8'd1);
        chk("dual_canal", 8'(canal), 8'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("idle_canal_hold", 8'(canal), 8'd0);
        al_en = 4'b1000;
        tick();
        chk("ch3_enc", 8'(enc), 8'd1);
        chk("ch3_canal", 8'(canal), 8'd3);

        // Snooze for 5 ticks; snooze while snoozed is ignored
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        chk("snz_enc", 8'(enc), 8'd0);
        chk("snz_pos", 8'(pospuesto), 8'd1);
        tick();
        tick();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        tick();
        tick();
        chk("snz4_pos", 8'(pospuesto), 8'd1);
        chk("snz4_enc", 8'(enc), 8'd0);
        tick();
        chk("snz5_enc", 8'(enc), 8'd1);
        chk("snz5_pos", 8'(pospuesto), 8'd0);
        chk("snz5_canal", 8'(canal), 8'd3);

        // Auto-off after 10 ticks of ringing
        for (int i = 0; i < 9; i++) tick();
        chk("ring9_enc", 8'(enc), 8'd1);
        tick();
        chk("ring10_enc", 8'(enc), 8'd0);
        step();
        chk("ring10_idle", 8'(enc), 8'd0);

        // Snooze and stop together: stop wins
        tick();
        chk("retrig_enc", 8'(enc), 8'd1);
        snooze = 1'b1;
        stop   = 1'b1;
        step();
        snooze = 1'b0;
        stop   = 1'b0;
        chk("both_enc", 8'(enc), 8'd0);
        chk("both_pos", 8'(pospuesto), 8'd0);

        // Channel 1 at 08:15: snooze beats timeout on the same tick
        al_en = 4'b0010;
        set_time(8, 15);
        tick();
        chk("ch1_canal", 8'(canal), 8'd1);
        for (int i = 0; i < 9; i++) tick();
        min_tick = 1'b1;
        snooze   = 1'b1;
        step();
        min_tick = 1'b0;
        snooze   = 1'b0;
        chk("snz_vs_to_pos", 8'(pospuesto), 8'd1);
        chk("snz_vs_to_enc", 8'(enc), 8'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("pos_stop_pos", 8'(pospuesto), 8'd0);
        chk("pos_stop_enc", 8'(enc), 8'd0);

        // Disabling the owning channel while ringing
        tick();
        chk("ch1_again_enc", 8'(enc), 8'd1);
        al_en = 4'b0000;
        step();
        chk("dis_enc", 8'(enc), 8'd0);
        chk("dis_canal", 8'(canal), 8'd1);

        // Asynchronous reset mid-ring
        al_en = 4'b0010;
        tick();
        chk("pre_rst_enc", 8'(enc), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_enc", 8'(enc), 8'd0);
        chk("async_rst_canal", 8'(canal), 8'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("post_rst_enc", 8'(enc), 8'd0);
        chk("post_rst_pos", 8'(pospuesto), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alarma_multicanal.md
ALARMA_MULTICANAL -- requirements
Module: alarma_multicanal

Interface
REQ-001 Parameter N_ALARMAS, default 4, number of independent alarm channels; legal range 1..8.
REQ-002 Parameter SNOOZE_MIN, default 5, snooze length in minute ticks; legal range 1..15.
REQ-003 Parameter RING_MIN, default 10, auto-off timeout in minute ticks while ringing; legal range 1..15.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 uhre, dhre, umre, dmre  input  4 each  clock time in BCD: hour units, hour tens, minute units, minute tens.
REQ-007 min_tick  input  1  one-cycle pulse, high in the first cycle the time inputs show a new minute.
REQ-008 al_time  input  16*N_ALARMAS  packed alarm times; channel k at bits [16k+15:16k], ordered {dh, uh, dm, um}, 4 bits each.
REQ-009 al_en  input  N_ALARMAS  per-channel enable, bit k for channel k.
REQ-010 snooze  input  1  one-cycle snooze request pulse.
REQ-011 stop  input  1  one-cycle stop request pulse.
REQ-012 enc  output  1  alarm sounding, registered.
REQ-013 pospuesto  output  1  snooze pending, registered.
REQ-014 canal  output  3  index of the channel that owns the current alarm, registered.

Function
REQ-015 Channel k SHALL match when al_en[k]=1 and all four alarm digits equal the corresponding time digits; raw 4-bit equality, no BCD validity check.
REQ-016 Matches SHALL be evaluated only in cycles where min_tick=1; a time held at the alarm value across further cycles SHALL NOT retrigger.
REQ-017 FSM states SHALL be REPOSO, SONANDO, POSPUESTO; enc=1 only in SONANDO, pospuesto=1 only in POSPUESTO.
REQ-018 REPOSO: on min_tick with one or more matches -> SONANDO next edge; canal latches the lowest matching index; ring counter cleared to 0.
REQ-019 SONANDO: stop -> REPOSO; else snooze -> POSPUESTO with snooze counter loaded to SNOOZE_MIN; else min_tick increments ring counter, and the tick that brings it to RING_MIN -> REPOSO.
REQ-020 Priority in SONANDO SHALL be stop > snooze > timeout when these occur in the same cycle.
REQ-021 POSPUESTO: stop -> REPOSO; else min_tick decrements snooze counter, and the tick that brings it to 0 -> SONANDO with ring counter cleared and canal unchanged.
REQ-022 snooze in POSPUESTO SHALL be ignored; snooze and stop in REPOSO SHALL be ignored.
REQ-023 New matches while in SONANDO or POSPUESTO SHALL be ignored and not queued.
REQ-024 Clearing al_en[canal] while in SONANDO or POSPUESTO SHALL force REPOSO next edge, with priority over all other events.
REQ-025 Transitions SHALL take effect at the first rising edge after the causing input; output latency exactly one cycle.
REQ-026 canal SHALL hold its value in REPOSO until the next trigger.
REQ-027 Ring counter and snooze counter SHALL each be 4 bits wide and never wrap.

Reset
REQ-028 rst_n=0 SHALL immediately, without clock, force REPOSO, enc=0, pospuesto=0, canal=0, and both counters to 0.
REQ-029 Reset asserted in any state SHALL discard the active alarm; after release no ring occurs until a new min_tick match.

Verification
REQ-030 Alarm ch2=07:30 enabled, time steps 07:29->07:30 with min_tick -> enc=1, canal=2 one cycle after tick; further cycles at 07:30 without tick -> no change.
REQ-031 ch0 and ch3 both 06:00 enabled, tick at 06:00 -> canal=0; ch0 disabled, repeat next day -> canal=3.
REQ-032 Ringing, snooze pulse -> enc=0, pospuesto=1; 5 min_ticks -> enc=1 after 5th tick, canal unchanged.
REQ-033 Ringing, no user input, 10 min_ticks -> enc=0, state REPOSO after 10th tick; snooze and stop same cycle while ringing -> REPOSO.
REQ-034 Ringing ch1, clear al_en[1] -> enc=0 next cycle; in POSPUESTO, stop -> pospuesto=0.
REQ-035 rst_n low mid-SONANDO between clock edges -> enc=0 immediately; release, no tick -> enc stays 0.
